// File: rtl/wb_sram_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_sram_arb_if : bus bundle for the two-master SRAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
interface wb_sram_arb_if #(
  parameter int adr_width = 32
);
  logic                 m0_cyc_i;
  logic                 m0_stb_i;
  logic                 m0_we_i;
  logic [adr_width-1:0] m0_adr_i;
  logic [3:0]           m0_sel_i;
  logic [31:0]          m0_dat_i;
  logic [31:0]          m0_dat_o;
  logic                 m0_ack_o;

  logic                 m1_cyc_i;
  logic                 m1_stb_i;
  logic                 m1_we_i;
  logic [adr_width-1:0] m1_adr_i;
  logic [3:0]           m1_sel_i;
  logic [31:0]          m1_dat_i;
  logic [31:0]          m1_dat_o;
  logic                 m1_ack_o;

  logic                 s_cyc_o;
  logic                 s_stb_o;
  logic                 s_we_o;
  logic [adr_width-1:0] s_adr_o;
  logic [3:0]           s_sel_o;
  logic [31:0]          s_dat_o;
  logic [31:0]          s_dat_i;
  logic                 s_ack_i;

  logic [1:0]           grant_o;

  // Arbiter view.
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
    input  s_dat_i, s_ack_i,
    output m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    output grant_o
  );

  // Surrounding-system view: both masters plus the SRAM controller.
  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i,
    output s_dat_i, s_ack_i,
    input  m0_dat_o, m0_ack_o, m1_dat_o, m1_ack_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    input  grant_o
  );
endinterface

`default_nettype wire

// File: rtl/wb_sram_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_sram_arb : round-robin two-master Wishbone arbiter for the SRAM port
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_sram_arb #(
  parameter int adr_width = 32,
  parameter int max_burst = 8
) (
  input  logic         clk,
  input  logic         reset,
  wb_sram_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_M0   = 2'd1,
    S_M1   = 2'd2
  } state_t;

  localparam logic [8:0] c_max_burst = 9'(max_burst);

  state_t      state_q;
  logic        last_q;
  logic        busy_q;
  logic [7:0]  bcount_q;
  logic [1:0]  grant_q;

  logic                 w_own0;
  logic                 w_own1;
  logic                 w_cyc_own;
  logic                 w_cyc_oth;
  logic                 w_s_cyc;
  logic                 w_s_stb;
  logic                 w_set;
  logic                 w_block;
  logic                 w_limit;
  logic                 w_rotate;
  logic                 w_release;
  logic [adr_width-1:0] w_adr;

  assign w_own0    = (state_q == S_M0);
  assign w_own1    = (state_q == S_M1);
  assign w_cyc_own = w_own1 ? bus.m1_cyc_i : bus.m0_cyc_i;
  assign w_cyc_oth = w_own1 ? bus.m0_cyc_i : bus.m1_cyc_i;

  assign w_s_cyc = (w_own0 & bus.m0_cyc_i) | (w_own1 & bus.m1_cyc_i);
  assign w_s_stb = (w_own0 & bus.m0_stb_i) | (w_own1 & bus.m1_stb_i);
  assign w_adr   = w_own1 ? bus.m1_adr_i : bus.m0_adr_i;

  assign bus.s_cyc_o = w_s_cyc;
  assign bus.s_stb_o = w_s_stb;
  assign bus.s_adr_o = w_adr;
  assign bus.s_we_o  = w_own1 ? bus.m1_we_i  : bus.m0_we_i;
  assign bus.s_sel_o = w_own1 ? bus.m1_sel_i : bus.m0_sel_i;
  assign bus.s_dat_o = w_own1 ? bus.m1_dat_i : bus.m0_dat_i;

  // An ack for an aborted cycle finds cyc low and is swallowed here.
  assign bus.m0_ack_o = w_own0 & bus.s_ack_i & bus.m0_cyc_i & bus.m0_stb_i;
  assign bus.m1_ack_o = w_own1 & bus.s_ack_i & bus.m1_cyc_i & bus.m1_stb_i;
  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.grant_o  = grant_q;

  assign w_set   = w_s_cyc & w_s_stb & ~bus.s_ack_i;
  assign w_block = w_set | (busy_q & ~bus.s_ack_i);

  // >= rather than == so a tenure that outran the limit while the other
  // master was quiet still yields on its next ack once a request appears.
  assign w_limit = (c_max_burst != 9'd0) & bus.s_ack_i &
                   (({1'b0, bcount_q} + 9'd1) >= c_max_burst);

  assign w_rotate  = ~w_block & (~w_cyc_own | w_limit) & w_cyc_oth;
  assign w_release = ~w_block & ~w_cyc_own & ~w_cyc_oth;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      busy_q   <= 1'b0;
      bcount_q <= 8'd0;
      grant_q  <= 2'b00;
    end else begin
      case (state_q)
        S_M0, S_M1: begin
          if (bus.s_ack_i) begin
            busy_q <= 1'b0;
          end else if (w_set) begin
            busy_q <= 1'b1;
          end

          if (w_rotate) begin
            state_q  <= w_own0 ? S_M1 : S_M0;
            last_q   <= w_own0;
            bcount_q <= 8'd0;
            grant_q  <= w_own0 ? 2'b10 : 2'b01;
          end else if (w_release) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
          end else if (bus.s_ack_i && (bcount_q != 8'hFF)) begin
            bcount_q <= bcount_q + 8'd1;
          end
        end

        default: begin
          // last_q = 1 means m1 owned last, so m0 takes a tie.
          if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_q)) begin
            state_q  <= S_M0;
            last_q   <= 1'b0;
            bcount_q <= 8'd0;
            grant_q  <= 2'b01;
          end else if (bus.m1_cyc_i) begin
            state_q  <= S_M1;
            last_q   <= 1'b1;
            bcount_q <= 8'd0;
            grant_q  <= 2'b10;
          end else begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_sram_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wb_sram_arb : directed bench, instance 0 has max_burst=4, instance 1 has 0
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_wb_sram_arb;

  localparam logic [31:0] c_dmask = 32'hDEAD_0000;

  logic clk = 1'b0;
  logic rst;

  logic [1:0]  cyc  [2];
  logic [1:0]  stb  [2];
  logic [1:0]  we   [2];
  logic [31:0] adr  [2][2];
  logic [3:0]  sel  [2][2];
  logic [31:0] wdat [2][2];

  logic [1:0]  ack   [2];
  logic [31:0] rdat  [2][2];
  logic [1:0]  grant [2];
  logic        s_cyc [2];
  logic        s_stb [2];
  logic        s_ack [2];

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] h_g   [100];
  logic       h_stb [100];
  logic       h_a0  [100];
  logic       h_a1  [100];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_inst
    wb_sram_arb_if #(.adr_width(32)) bus ();

    wb_sram_arb #(
      .adr_width (32),
      .max_burst ((i == 0) ? 4 : 0)
    ) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
    );

    assign bus.m0_cyc_i = cyc[i][0];
    assign bus.m0_stb_i = stb[i][0];
    assign bus.m0_we_i  = we[i][0];
    assign bus.m0_adr_i = adr[i][0];
    assign bus.m0_sel_i = sel[i][0];
    assign bus.m0_dat_i = wdat[i][0];
    assign bus.m1_cyc_i = cyc[i][1];
    assign bus.m1_stb_i = stb[i][1];
    assign bus.m1_we_i  = we[i][1];
    assign bus.m1_adr_i = adr[i][1];
    assign bus.m1_sel_i = sel[i][1];
    assign bus.m1_dat_i = wdat[i][1];

    assign ack[i]     = {bus.m1_ack_o, bus.m0_ack_o};
    assign rdat[i][0] = bus.m0_dat_o;
    assign rdat[i][1] = bus.m1_dat_o;
    assign grant[i]   = bus.grant_o;
    assign s_cyc[i]   = bus.s_cyc_o;
    assign s_stb[i]   = bus.s_stb_o;
    assign s_ack[i]   = bus.s_ack_i;

    // Controller model: one wait state, three for a partial (RMW) write.
    logic       pend;
    logic       sack;
    logic [1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        pend <= 1'b0;
        sack <= 1'b0;
        cnt  <= 2'd0;
      end else begin
        sack <= 1'b0;
        if (pend) begin
          if (cnt == 2'd0) begin
            sack <= 1'b1;
            pend <= 1'b0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end else if (bus.s_cyc_o && bus.s_stb_o && !sack) begin
          if (bus.s_we_o && (bus.s_sel_o != 4'hF)) begin
            pend <= 1'b1;
            cnt  <= 2'd1;
          end else begin
            sack <= 1'b1;
          end
        end
      end
    end
    assign bus.s_ack_i = sack;
    assign bus.s_dat_i = sack ? (bus.s_adr_o ^ c_dmask) : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Sequential transfers at base, base+4, ... holding cyc across the burst.
  task automatic master_run(input int k, input int m, input int n, input logic [31:0] base,
                            input logic w, input logic [3:0] s, output int acks);
    int t;
    acks = 0;
    tick();
    if (n > 0) begin
      cyc[k][m]  = 1'b1;
      stb[k][m]  = 1'b1;
      we[k][m]   = w;
      sel[k][m]  = s;
      adr[k][m]  = base;
      wdat[k][m] = base ^ 32'h1234_5678;
      t = 0;
      while (acks < n && t < 300) begin
        @(negedge clk);
        t++;
        if (ack[k][m]) begin
          if (!w)
            chk($sformatf("rdata i%0d m%0d #%0d", k, m, acks), rdat[k][m],
                (base + 32'(4 * acks)) ^ c_dmask);
          acks++;
          tick();
          if (acks < n) adr[k][m] = base + 32'(4 * acks);
        end
      end
      if (acks < n) chk($sformatf("timeout i%0d m%0d", k, m), 32'(acks), 32'(n));
      cyc[k][m] = 1'b0;
      stb[k][m] = 1'b0;
    end
  endtask

  task automatic run_pair(input int k,
                          input int n0, input logic [31:0] b0, input logic w0, input logic [3:0] s0,
                          input int n1, input logic [31:0] b1, input logic w1, input logic [3:0] s1,
                          output int a0, output int a1);
    bit d0, d1;
    int r0, r1;
    d0 = 1'b0;
    d1 = 1'b0;
    fork
      begin
        master_run(k, 0, n0, b0, w0, s0, r0);
        d0 = 1'b1;
      end
      begin
        master_run(k, 1, n1, b1, w1, s1, r1);
        d1 = 1'b1;
      end
      begin
        int extra;
        extra = 0;
        for (int t = 0; t < 100; t++) begin
          h_g[t] = 2'b00; h_stb[t] = 1'b0; h_a0[t] = 1'b0; h_a1[t] = 1'b0;
        end
        tick();
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          h_g[t]   = grant[k];
          h_stb[t] = s_stb[k];
          h_a0[t]  = ack[k][0];
          h_a1[t]  = ack[k][1];
          if (d0 && d1) begin
            extra++;
            if (extra > 3) break;
          end
        end
      end
    join
    a0 = r0;
    a1 = r1;
  endtask

  function automatic int m0_acks_before_m1();
    int c;
    c = 0;
    for (int t = 0; t < 100; t++) begin
      if (h_g[t] == 2'b10) return c;
      if (h_a0[t]) c++;
    end
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc[k] = 2'b00; stb[k] = 2'b00; we[k] = 2'b00;
      for (int m = 0; m < 2; m++) begin
        adr[k][m] = 32'h0; sel[k][m] = 4'h0; wdat[k][m] = 32'h0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state of both instances
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst grant i%0d", k), 32'(grant[k]), 32'h0);
      chk($sformatf("rst s_cyc/stb i%0d", k), 32'({s_cyc[k], s_stb[k]}), 32'h0);
      chk($sformatf("rst acks i%0d", k), 32'(ack[k]), 32'h0);
    end

    // Single master read of 0x100
    run_pair(0, 1, 32'h100, 1'b0, 4'hF, 0, 32'h0, 1'b0, 4'hF, a0, a1);
    chk("single grant C0", 32'(h_g[0]), 32'h0);
    chk("single stb C0", 32'(h_stb[0]), 32'h0);
    chk("single grant C1", 32'(h_g[1]), 32'h1);
    chk("single stb C1", 32'(h_stb[1]), 32'h1);
    chk("single ack0 C1", 32'(h_a0[1]), 32'h0);
    chk("single ack0 C2", 32'(h_a0[2]), 32'h1);
    chk("single ack1 C2", 32'(h_a1[2]), 32'h0);
    chk("single idle C4", 32'(h_g[4]), 32'h0);
    chk("single acks", 32'(a0), 32'd1);

    // Tie after reset, one write each, then a second tie
    do_reset();
    run_pair(0, 1, 32'h200, 1'b1, 4'hF, 1, 32'h300, 1'b1, 4'hF, a0, a1);
    chk("tie grant C1", 32'(h_g[1]), 32'h1);
    chk("tie grant C3", 32'(h_g[3]), 32'h1);
    chk("tie handover C4", 32'(h_g[4]), 32'h2);
    chk("tie m1 ack C5", 32'(h_a1[5]), 32'h1);
    chk("tie idle C7", 32'(h_g[7]), 32'h0);
    chk("tie acks", 32'({a1[7:0], a0[7:0]}), 32'h0101);
    run_pair(0, 1, 32'h210, 1'b1, 4'hF, 1, 32'h310, 1'b1, 4'hF, a0, a1);
    chk("tie2 grant C1", 32'(h_g[1]), 32'h1);
    chk("tie2 handover C4", 32'(h_g[4]), 32'h2);

    // Burst limit 4
    do_reset();
    run_pair(0, 12, 32'h1000, 1'b0, 4'hF, 3, 32'h2000, 1'b0, 4'hF, a0, a1);
    chk("burst4 m0 acks before m1", 32'(m0_acks_before_m1()), 32'd4);
    chk("burst4 m0 total", 32'(a0), 32'd12);
    chk("burst4 m1 total", 32'(a1), 32'd3);

    // Unlimited burst
    do_reset();
    run_pair(1, 20, 32'h3000, 1'b0, 4'hF, 3, 32'h4000, 1'b0, 4'hF, a0, a1);
    chk("burst0 m0 acks before m1", 32'(m0_acks_before_m1()), 32'd20);
    chk("burst0 m0 total", 32'(a0), 32'd20);
    chk("burst0 m1 total", 32'(a1), 32'd3);

    // Abort of a byte write while m1 waits
    do_reset();
    tick();
    cyc[0] = 2'b11; stb[0] = 2'b11; we[0] = 2'b01;
    adr[0][0] = 32'h500; sel[0][0] = 4'h1;
    adr[0][1] = 32'h600; sel[0][1] = 4'hF;
    @(negedge clk);
    chk("abort grant C0", 32'(grant[0]), 32'h0);
    tick();
    @(negedge clk);
    chk("abort grant C1", 32'(grant[0]), 32'h1);
    chk("abort stb C1", 32'(s_stb[0]), 32'h1);
    tick();
    cyc[0][0] = 1'b0; stb[0][0] = 1'b0;
    @(negedge clk);
    chk("abort hold C2", 32'(grant[0]), 32'h1);
    tick();
    @(negedge clk);
    chk("abort hold C3", 32'({grant[0], s_ack[0]}), 32'h2);
    tick();
    @(negedge clk);
    chk("abort ack C4", 32'({grant[0], s_ack[0]}), 32'h3);
    chk("abort ack swallowed C4", 32'(ack[0]), 32'h0);
    tick();
    @(negedge clk);
    chk("abort handover C5", 32'(grant[0]), 32'h2);
    chk("abort acks C5", 32'(ack[0]), 32'h0);
    tick();
    @(negedge clk);
    chk("abort m1 ack C6", 32'(ack[0]), 32'h2);
    chk("abort m1 data C6", rdat[0][1], 32'h600 ^ c_dmask);
    tick();
    cyc[0][1] = 1'b0; stb[0][1] = 1'b0;

    // Reset while busy, then arbitration resumes with m0 winning the tie
    repeat (2) tick();
    cyc[0][0] = 1'b1; stb[0][0] = 1'b1; we[0][0] = 1'b1;
    adr[0][0] = 32'h700; sel[0][0] = 4'h2;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstbusy grant C2", 32'(grant[0]), 32'h1);
    tick();
    rst = 1'b0;
    cyc[0][0] = 1'b0; stb[0][0] = 1'b0;
    @(negedge clk);
    chk("rstbusy grant C3", 32'(grant[0]), 32'h0);
    chk("rstbusy stb C3", 32'(s_stb[0]), 32'h0);
    chk("rstbusy acks C3", 32'(ack[0]), 32'h0);
    tick();
    @(negedge clk);
    chk("rstbusy no late ack C4", 32'(s_ack[0]), 32'h0);
    run_pair(0, 1, 32'h800, 1'b0, 4'hF, 1, 32'h900, 1'b0, 4'hF, a0, a1);
    chk("rstbusy tie grant C1", 32'(h_g[1]), 32'h1);
    chk("rstbusy handover C4", 32'(h_g[4]), 32'h2);
    chk("rstbusy acks", 32'({a1[7:0], a0[7:0]}), 32'h0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
